// File: rtl/gf_mem_pkg.sv
// Shared types and constants for the GF SRAM power-managed wrapper.
package gf_mem_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DSLEEP = 2'd1,
    PGATE  = 2'd2,
    WAKE   = 2'd3
  } pwr_state_e;

  // Functional defaults for the macro margin/redundancy pins
  localparam logic [1:0] MA_SAWL  = 2'b11;
  localparam logic [1:0] MA_WL    = 2'b00;
  localparam logic [1:0] MA_WRAS  = 2'b10;
  localparam logic       MA_WRASD = 1'b0;
  localparam logic       RBE      = 1'b0;
  localparam logic       RBF0A    = 1'b0;

  function automatic bit words_legal(input int words);
    return (words == 512) || (words == 1024) || (words == 2048) || (words == 4096);
  endfunction

endpackage

// File: rtl/gf_mems1d_model.sv
// Behavioural stand-in for the MEMS1D_BUFG hard macros: one shared core plus
// thin per-depth shells so the wrapper elaborates without the vendor library.
module gf_mems1d_model #(
  parameter int WORDS = 2048,
  parameter int AS_W  = 2,
  parameter int AW_W  = 7
) (
  input  logic            CLK,
  input  logic            CEN,
  input  logic            RDWEN,
  input  logic            DEEPSLEEP,
  input  logic            POWERGATE,
  input  logic [AS_W-1:0] AS,
  input  logic [AW_W-1:0] AW,
  input  logic [1:0]      AC,
  input  logic [31:0]     D,
  input  logic [31:0]     BW,
  input  logic            T_LOGIC,
  input  logic            T_BIST,
  input  logic [1:0]      MA_SAWL,
  input  logic [1:0]      MA_WL,
  input  logic [1:0]      MA_WRAS,
  input  logic            MA_WRASD,
  input  logic            RBE,
  input  logic            RBF0A,
  output logic [31:0]     Q
);

  logic [31:0]             mem [WORDS];
  logic [AS_W+AW_W+1:0]    idx;
  logic                    access;
  logic                    unused_pins;

  assign idx         = {AS, AW, AC};
  assign access      = ~CEN & ~DEEPSLEEP & ~POWERGATE & ~T_LOGIC & ~T_BIST;
  assign unused_pins = ^{MA_SAWL, MA_WL, MA_WRAS, MA_WRASD, RBE, RBF0A};

  always_ff @(posedge CLK) begin
    if (access) begin
      if (!RDWEN) begin
        mem[idx] <= (mem[idx] & ~BW) | (D & BW);
      end else begin
        Q <= mem[idx];
      end
    end
  end

endmodule

`define GF_MEMS1D_SHELL(NAME, DEPTH, ASW, AWW) \
module NAME ( \
  input  logic           CLK, \
  input  logic           CEN, \
  input  logic           RDWEN, \
  input  logic           DEEPSLEEP, \
  input  logic           POWERGATE, \
  input  logic [ASW-1:0] AS, \
  input  logic [AWW-1:0] AW, \
  input  logic [1:0]     AC, \
  input  logic [31:0]    D, \
  input  logic [31:0]    BW, \
  input  logic           T_LOGIC, \
  input  logic           T_BIST, \
  input  logic [1:0]     MA_SAWL, \
  input  logic [1:0]     MA_WL, \
  input  logic [1:0]     MA_WRAS, \
  input  logic           MA_WRASD, \
  input  logic           RBE, \
  input  logic           RBF0A, \
  output logic [31:0]    Q \
); \
  gf_mems1d_model #(.WORDS(DEPTH), .AS_W(ASW), .AW_W(AWW)) u_core (.*); \
endmodule

`GF_MEMS1D_SHELL(MEMS1D_BUFG_512x32,  512,  1, 6)
`GF_MEMS1D_SHELL(MEMS1D_BUFG_1024x32, 1024, 1, 7)
`GF_MEMS1D_SHELL(MEMS1D_BUFG_2048x32, 2048, 2, 7)
`GF_MEMS1D_SHELL(MEMS1D_BUFG_4096x32, 4096, 3, 7)

`undef GF_MEMS1D_SHELL

// File: rtl/gf_sram_macro_sel.sv
// Picks the MEMS1D_BUFG macro matching WORDS and ties its test/margin pins.
module gf_sram_macro_sel
  import gf_mem_pkg::*;
#(
  parameter int WORDS  = 2048,
  parameter int DATA_W = 32,
  parameter int AS_W   = 2,
  parameter int AW_W   = 7,
  parameter int AC_W   = 2
) (
  input  logic              clk_i,
  input  logic              cen,
  input  logic              rdwen,
  input  logic              deepsleep,
  input  logic              powergate,
  input  logic [AS_W-1:0]   as_addr,
  input  logic [AW_W-1:0]   aw_addr,
  input  logic [AC_W-1:0]   ac_addr,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] bw,
  output logic [DATA_W-1:0] q
);

`define GF_MACRO_PINS \
  .CLK(clk_i), .CEN(cen), .RDWEN(rdwen), .DEEPSLEEP(deepsleep), .POWERGATE(powergate), \
  .AS(as_addr), .AW(aw_addr), .AC(ac_addr), .D(d), .BW(bw), .Q(q), \
  .T_LOGIC(1'b0), .T_BIST(1'b0), \
  .MA_SAWL(MA_SAWL), .MA_WL(MA_WL), .MA_WRAS(MA_WRAS), .MA_WRASD(MA_WRASD), \
  .RBE(RBE), .RBF0A(RBF0A)

  generate
    case (WORDS)
      512:     begin : g_512  MEMS1D_BUFG_512x32  u_macro (`GF_MACRO_PINS); end
      1024:    begin : g_1024 MEMS1D_BUFG_1024x32 u_macro (`GF_MACRO_PINS); end
      2048:    begin : g_2048 MEMS1D_BUFG_2048x32 u_macro (`GF_MACRO_PINS); end
      4096:    begin : g_4096 MEMS1D_BUFG_4096x32 u_macro (`GF_MACRO_PINS); end
      default: begin : g_none assign q = '0; end
    endcase
  endgenerate

`undef GF_MACRO_PINS

endmodule

// File: rtl/gf_sram_pwr_ctrl.sv
// req/gnt/rvalid front end for one GF SRAM macro with deepsleep/powergate
// sequencing, wake-up delay and automatic idle sleep.
module gf_sram_pwr_ctrl
  import gf_mem_pkg::*;
#(
  parameter int WORDS       = 2048,
  parameter int DATA_W      = 32,
  parameter int AC_W        = 2,
  parameter int AW_W        = (WORDS == 512) ? 6 : 7,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16,
  localparam int ADDR_W     = $clog2(WORDS),
  localparam int AS_W       = ADDR_W - AW_W - AC_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  input  logic                sleep_en_i,
  input  logic                pgate_req_i,
  output logic [1:0]          pwr_state_o,
  output logic                data_lost_o
);

  localparam int              IC_W      = $clog2(IDLE_CYCLES + 1);
  localparam int              WC_W      = $clog2(WAKE_CYCLES + 1);
  localparam logic [IC_W-1:0] IDLE_MAX  = IC_W'(IDLE_CYCLES);
  localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(IDLE_CYCLES - 1);
  localparam logic [WC_W-1:0] WAKE_LAST = WC_W'(WAKE_CYCLES - 1);
  localparam bit              WORDS_OK  = words_legal(WORDS);

  pwr_state_e        state, state_nxt;
  logic [IC_W-1:0]   idle_cnt;
  logic [WC_W-1:0]   wake_cnt;
  logic              deepsleep_q, powergate_q, data_lost_q;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1, q, bw;

  // An unsupported depth has no macro behind it, so it never grants
  assign gnt_o       = WORDS_OK && !rst_i && req_i && (state == ACTIVE) && !pgate_req_i;
  assign pwr_state_o = state;
  assign data_lost_o = data_lost_q;
  assign rvalid_o    = vld_p1;
  assign rdata_o     = vld_p1 ? q : rdata_p1;

  always_comb begin
    bw = '1;
    for (int i = 0; i < DATA_W; i++) bw[i] = ~we_i | be_i[i/8];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACTIVE: begin
        if (pgate_req_i) state_nxt = PGATE;
        else if (sleep_en_i && !req_i && idle_cnt >= IDLE_LAST) state_nxt = DSLEEP;
      end
      DSLEEP: begin
        if (pgate_req_i) state_nxt = PGATE;
        else if (req_i || !sleep_en_i) state_nxt = WAKE;
      end
      PGATE: begin
        if (!pgate_req_i) state_nxt = WAKE;
      end
      WAKE: begin
        if (pgate_req_i) state_nxt = PGATE;
        else if (wake_cnt == WAKE_LAST) state_nxt = ACTIVE;
      end
      default: state_nxt = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ACTIVE;
      idle_cnt    <= '0;
      wake_cnt    <= '0;
      deepsleep_q <= 1'b0;
      powergate_q <= 1'b0;
      data_lost_q <= 1'b0;
      vld_p1      <= 1'b0;
      rdata_p1    <= '0;
    end else begin
      state <= state_nxt;
      if (state != ACTIVE || req_i || !sleep_en_i) idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)               idle_cnt <= idle_cnt + 1'b1;
      wake_cnt    <= (state == WAKE && state_nxt == WAKE) ? wake_cnt + 1'b1 : '0;
      // Pins follow the state being entered so they line up with pwr_state_o
      deepsleep_q <= (state_nxt == DSLEEP);
      powergate_q <= (state_nxt == PGATE);
      if (state_nxt == PGATE && state != PGATE) data_lost_q <= 1'b1;
      // p1: read response stage, macro Q is valid the cycle after the grant
      vld_p1 <= gnt_o & ~we_i;
      if (vld_p1) rdata_p1 <= q;
    end
  end

  gf_sram_macro_sel #(
    .WORDS (WORDS),
    .DATA_W(DATA_W),
    .AS_W  (AS_W),
    .AW_W  (AW_W),
    .AC_W  (AC_W)
  ) u_macro_sel (
    .clk_i    (clk_i),
    .cen      (~gnt_o),
    .rdwen    (~we_i),
    .deepsleep(deepsleep_q),
    .powergate(powergate_q),
    .as_addr  (addr_i[ADDR_W-1 -: AS_W]),
    .aw_addr  (addr_i[AC_W +: AW_W]),
    .ac_addr  (addr_i[AC_W-1:0]),
    .d        (wdata_i),
    .bw       (bw),
    .q        (q)
  );

endmodule
